// File: rtl/obuf_reader.sv
// Output-buffer drain: reads N words from RAM address 0 and streams them out on valid/ready.
// Optional feature macro: OBUF_RD_CHKSUM_EN adds o_chksum, the XOR of every transferred word.
module obuf_reader #(
    parameter int VL     = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_W:0]        i_num_words,
    output logic                   o_rd_en,
    output logic [ADDR_W-1:0]      o_rd_addr,
    input  logic [VL*DATA_W-1:0]   i_rd_data,
    output logic [VL*DATA_W-1:0]   o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done
`ifdef OBUF_RD_CHKSUM_EN
   ,output logic [VL*DATA_W-1:0]   o_chksum
`endif
);

    localparam int W  = VL * DATA_W;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   num_words;
    logic [CW-1:0]   num_clamped;
    logic [CW-1:0]   issued_cnt;
    logic [CW-1:0]   sent_cnt;
    logic            inflight;
    logic            start_acc;

    logic [W-1:0]    fifo_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      stored_cnt;
    logic [1:0]      occ_after;
    logic            fifo_valid;
    logic            xfer;
    logic            store;
    logic            deq;

    assign num_clamped = (i_num_words > MAX_WORDS) ? MAX_WORDS : i_num_words;
    assign start_acc   = i_start && (state == ST_IDLE);

    // The word returning from RAM is visible at the FIFO head in the cycle it arrives,
    // so an empty FIFO adds no latency; it is only stored if the host does not take it.
    assign fifo_valid = (stored_cnt != 2'd0) || inflight;
    assign xfer       = fifo_valid && i_ready;
    assign store      = inflight && !((stored_cnt == 2'd0) && xfer);
    assign deq        = xfer && (stored_cnt != 2'd0);
    assign occ_after  = stored_cnt + 2'(inflight) - 2'(xfer);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = (num_clamped == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (o_rd_en && (issued_cnt == num_words - CW'(1))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && (sent_cnt == num_words - CW'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state != ST_IDLE);
        o_done    = (state == ST_DONE);
        o_valid   = fifo_valid;
        o_rd_addr = issued_cnt[ADDR_W-1:0];
        o_rd_en   = (state == ST_READ) && (issued_cnt < num_words) && (occ_after < 2'd2);
        o_data    = '0;
        if (stored_cnt != 2'd0) begin
            o_data = fifo_mem[rd_ptr];
        end else if (inflight) begin
            o_data = i_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_words  <= '0;
            issued_cnt <= '0;
            sent_cnt   <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            stored_cnt <= 2'd0;
        end else begin
            inflight <= o_rd_en;
            if (start_acc) begin
                num_words  <= num_clamped;
                issued_cnt <= '0;
                sent_cnt   <= '0;
            end else begin
                if (o_rd_en) issued_cnt <= issued_cnt + CW'(1);
                if (xfer)    sent_cnt   <= sent_cnt + CW'(1);
            end
            if (store) wr_ptr <= ~wr_ptr;
            if (deq)   rd_ptr <= ~rd_ptr;
            stored_cnt <= stored_cnt + 2'(store) - 2'(deq);
        end
    end

    // NOTE: FIFO storage has no reset; stored_cnt alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (store) begin
            fifo_mem[wr_ptr] <= i_rd_data;
        end
    end

`ifdef OBUF_RD_CHKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_chksum <= '0;
        end else if (start_acc) begin
            o_chksum <= '0;
        end else if (xfer) begin
            o_chksum <= o_chksum ^ o_data;
        end
    end
`endif

endmodule

// File: tb/tb_obuf_reader.sv
// Directed bench for obuf_reader: a behavioural 1-cycle RAM feeds the DUT; each task checks one scenario.
module tb_obuf_reader;

    localparam int VL     = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int W      = VL * DATA_W;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic [ADDR_W:0]   i_num_words;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [W-1:0]      i_rd_data = '0;
    logic [W-1:0]      o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_busy;
    logic              o_done;
`ifdef OBUF_RD_CHKSUM_EN
    logic [W-1:0]      o_chksum;
`endif

    int                n_vec = 0;
    int                n_err = 0;
    logic [63:0]       salt;
    logic [W-1:0]      ram_mem [0:1023];

    always #5 i_clk = ~i_clk;

    obuf_reader #(.VL(VL), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_num_words (i_num_words),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
`ifdef OBUF_RD_CHKSUM_EN
       ,.o_chksum    (o_chksum)
`endif
    );

    // Synchronous RAM: data for the address presented with o_rd_en appears the next cycle.
    always @(posedge i_clk) begin
        if (o_rd_en) i_rd_data <= ram_mem[o_rd_addr];
    end

    function automatic logic [W-1:0] pat(input int k, input logic [63:0] s);
        return {s, 64'(k)};
    endfunction

    task automatic fill_ram(input logic [63:0] s);
        salt = s;
        for (int k = 0; k < 1024; k++) ram_mem[k] = pat(k, s);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_ready = 1'b0; i_num_words = '0;
        repeat (2) @(negedge i_clk);
        #1;
        n_vec++; if (o_busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        n_vec++; if (o_done !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%b want=0", o_done); end
        n_vec++; if (o_rd_en !== 1'b0)  begin n_err++; $display("FAIL reset_rd_en got=%b want=0", o_rd_en); end
        n_vec++; if (o_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        n_vec++; if (o_rd_addr !== '0)  begin n_err++; $display("FAIL reset_rd_addr got=%h want=0", o_rd_addr); end
        n_vec++; if (o_data !== '0)     begin n_err++; $display("FAIL reset_data got=%h want=0", o_data); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // N=4 with i_ready held high: rd_addr 0..3 on cycles 1-4, o_valid 2-5, o_done on 6.
    task automatic test_basic();
        fill_ram(64'h0);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd4;
        #1;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_c0 got=%b want=0", o_busy); end
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            n_vec++;
            if (o_rd_en !== (cyc >= 1 && cyc <= 4)) begin
                n_err++; $display("FAIL basic_rd_en c%0d got=%b want=%b", cyc, o_rd_en, (cyc >= 1 && cyc <= 4));
            end
            if (cyc <= 4) begin
                n_vec++;
                if (o_rd_addr !== ADDR_W'(cyc - 1)) begin
                    n_err++; $display("FAIL basic_rd_addr c%0d got=%0d want=%0d", cyc, o_rd_addr, cyc - 1);
                end
            end
            n_vec++;
            if (o_valid !== (cyc >= 2 && cyc <= 5)) begin
                n_err++; $display("FAIL basic_valid c%0d got=%b want=%b", cyc, o_valid, (cyc >= 2 && cyc <= 5));
            end
            if (cyc >= 2 && cyc <= 5) begin
                n_vec++;
                if (o_data !== W'(cyc - 2)) begin
                    n_err++; $display("FAIL basic_data c%0d got=%h want=%h", cyc, o_data, W'(cyc - 2));
                end
            end
            n_vec++;
            if (o_done !== (cyc == 6)) begin
                n_err++; $display("FAIL basic_done c%0d got=%b want=%b", cyc, o_done, (cyc == 6));
            end
            n_vec++;
            if (o_busy !== (cyc <= 6)) begin
                n_err++; $display("FAIL basic_busy c%0d got=%b want=%b", cyc, o_busy, (cyc <= 6));
            end
        end
    endtask

    // N=8 with i_ready toggling: order, no loss/duplication, stable stalled data, outstanding <= 2.
    task automatic test_backpressure();
        int   issued = 0;
        int   sent = 0;
        logic stalled = 1'b0;
        logic done_seen = 1'b0;
        logic [W-1:0] held = '0;
        fill_ram(64'hA5A5_0000_0000_0001);
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd8; i_ready = 1'b1;
        for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_ready = (cyc % 2 == 1);
            #1;
            n_vec++;
            if (issued - sent > 2) begin
                n_err++; $display("FAIL bp_outstanding c%0d got=%0d want<=2", cyc, issued - sent);
            end
            if (stalled) begin
                n_vec++;
                if (!o_valid || o_data !== held) begin
                    n_err++; $display("FAIL bp_stable c%0d got=%b/%h want=1/%h", cyc, o_valid, o_data, held);
                end
            end
            if (o_rd_en) begin
                n_vec++;
                if (o_rd_addr !== ADDR_W'(issued)) begin
                    n_err++; $display("FAIL bp_rd_addr c%0d got=%0d want=%0d", cyc, o_rd_addr, issued);
                end
                issued++;
            end
            if (o_valid && i_ready) begin
                n_vec++;
                if (o_data !== pat(sent, salt)) begin
                    n_err++; $display("FAIL bp_data word%0d got=%h want=%h", sent, o_data, pat(sent, salt));
                end
                sent++;
            end
            if (o_done) done_seen = 1'b1;
            stalled = o_valid && !i_ready;
            held    = o_data;
        end
        n_vec++; if (!done_seen) begin n_err++; $display("FAIL bp_timeout got=no_done want=done"); end
        n_vec++; if (sent != 8)   begin n_err++; $display("FAIL bp_sent got=%0d want=8", sent); end
        n_vec++; if (issued != 8) begin n_err++; $display("FAIL bp_issued got=%0d want=8", issued); end
    endtask

    task automatic test_zero();
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            n_vec++; if (o_busy !== (cyc == 1)) begin n_err++; $display("FAIL zero_busy c%0d got=%b want=%b", cyc, o_busy, (cyc == 1)); end
            n_vec++; if (o_done !== (cyc == 1)) begin n_err++; $display("FAIL zero_done c%0d got=%b want=%b", cyc, o_done, (cyc == 1)); end
            n_vec++; if (o_rd_en !== 1'b0)      begin n_err++; $display("FAIL zero_rd_en c%0d got=%b want=0", cyc, o_rd_en); end
            n_vec++; if (o_valid !== 1'b0)      begin n_err++; $display("FAIL zero_valid c%0d got=%b want=0", cyc, o_valid); end
        end
    endtask

    // Full buffer (and clamped oversize request): 1024 reads, 1024 transfers, o_done at cycle 1026.
    task automatic test_full(input logic [ADDR_W:0] n);
        int   sent = 0;
        int   last_addr = -1;
        logic done_seen = 1'b0;
        fill_ram(64'h0123_4567_89AB_CDEF ^ 64'(n));
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = n;
        for (int cyc = 1; cyc <= 1100 && !done_seen; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            n_vec++;
            if (o_rd_en !== (cyc <= 1024)) begin
                n_err++; $display("FAIL full_rd_en n=%0d c%0d got=%b want=%b", n, cyc, o_rd_en, (cyc <= 1024));
            end
            if (o_rd_en) begin
                n_vec++;
                if (o_rd_addr !== ADDR_W'(cyc - 1)) begin
                    n_err++; $display("FAIL full_rd_addr c%0d got=%0d want=%0d", cyc, o_rd_addr, cyc - 1);
                end
                last_addr = int'(o_rd_addr);
            end
            n_vec++;
            if (o_valid !== (cyc >= 2 && cyc <= 1025)) begin
                n_err++; $display("FAIL full_valid c%0d got=%b want=%b", cyc, o_valid, (cyc >= 2 && cyc <= 1025));
            end
            if (o_valid) begin
                n_vec++;
                if (o_data !== pat(sent, salt)) begin
                    n_err++; $display("FAIL full_data word%0d got=%h want=%h", sent, o_data, pat(sent, salt));
                end
                sent++;
            end
            n_vec++;
            if (o_done !== (cyc == 1026)) begin
                n_err++; $display("FAIL full_done c%0d got=%b want=%b", cyc, o_done, (cyc == 1026));
            end
            if (o_done) done_seen = 1'b1;
        end
        n_vec++; if (!done_seen)        begin n_err++; $display("FAIL full_timeout n=%0d got=no_done want=done", n); end
        n_vec++; if (sent != 1024)      begin n_err++; $display("FAIL full_count n=%0d got=%0d want=1024", n, sent); end
        n_vec++; if (last_addr != 1023) begin n_err++; $display("FAIL full_last_addr n=%0d got=%0d want=1023", n, last_addr); end
    endtask

    // N=6 with a start pulse mid-drain and another in the o_done cycle; both must be ignored.
    task automatic test_restart();
        fill_ram(64'hDEAD_BEEF_0000_0006);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd6;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge i_clk);
            i_start = (cyc == 3 || cyc == 8);
            i_num_words = 11'd2;
            #1;
            n_vec++;
            if (o_rd_en !== (cyc <= 6)) begin
                n_err++; $display("FAIL rs_rd_en c%0d got=%b want=%b", cyc, o_rd_en, (cyc <= 6));
            end
            n_vec++;
            if (o_valid !== (cyc >= 2 && cyc <= 7)) begin
                n_err++; $display("FAIL rs_valid c%0d got=%b want=%b", cyc, o_valid, (cyc >= 2 && cyc <= 7));
            end
            if (cyc >= 2 && cyc <= 7) begin
                n_vec++;
                if (o_data !== pat(cyc - 2, salt)) begin
                    n_err++; $display("FAIL rs_data c%0d got=%h want=%h", cyc, o_data, pat(cyc - 2, salt));
                end
            end
            n_vec++;
            if (o_done !== (cyc == 8)) begin
                n_err++; $display("FAIL rs_done c%0d got=%b want=%b", cyc, o_done, (cyc == 8));
            end
            n_vec++;
            if (o_busy !== (cyc <= 8)) begin
                n_err++; $display("FAIL rs_busy c%0d got=%b want=%b", cyc, o_busy, (cyc <= 8));
            end
        end
        i_start = 1'b0;
    endtask

    // Reset mid-drain clears everything at once; a fresh N=2 drain must show no stale words.
    task automatic test_reset_mid();
        fill_ram(64'h5555_0000_0000_0000);
        i_ready = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd6;
        repeat (3) begin
            @(negedge i_clk);
            i_start = 1'b0;
        end
        #1;
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid got=%b want=1", o_valid); end
        i_rst_n = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%b want=0", o_valid); end
        n_vec++; if (o_busy !== 1'b0)  begin n_err++; $display("FAIL rm_busy got=%b want=0", o_busy); end
        n_vec++; if (o_rd_en !== 1'b0) begin n_err++; $display("FAIL rm_rd_en got=%b want=0", o_rd_en); end
        n_vec++; if (o_data !== '0)    begin n_err++; $display("FAIL rm_data got=%h want=0", o_data); end
        @(negedge i_clk);
        #1;
        n_vec++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL rm_hold got=%b/%b want=0/0", o_valid, o_busy);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fill_ram(64'hAAAA_0000_0000_0002);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd2;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            #1;
            n_vec++;
            if (o_rd_en !== (cyc <= 2)) begin
                n_err++; $display("FAIL rm2_rd_en c%0d got=%b want=%b", cyc, o_rd_en, (cyc <= 2));
            end
            n_vec++;
            if (o_valid !== (cyc == 2 || cyc == 3)) begin
                n_err++; $display("FAIL rm2_valid c%0d got=%b want=%b", cyc, o_valid, (cyc == 2 || cyc == 3));
            end
            if (cyc == 2 || cyc == 3) begin
                n_vec++;
                if (o_data !== pat(cyc - 2, salt)) begin
                    n_err++; $display("FAIL rm2_data c%0d got=%h want=%h", cyc, o_data, pat(cyc - 2, salt));
                end
            end
            n_vec++;
            if (o_done !== (cyc == 4)) begin
                n_err++; $display("FAIL rm2_done c%0d got=%b want=%b", cyc, o_done, (cyc == 4));
            end
        end
    endtask

`ifdef OBUF_RD_CHKSUM_EN
    task automatic test_chksum();
        logic done_seen = 1'b0;
        ram_mem[0] = W'(1); ram_mem[1] = W'(2); ram_mem[2] = W'(4);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 11'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        #1;
        n_vec++; if (o_chksum !== '0) begin n_err++; $display("FAIL ck_clear got=%h want=0", o_chksum); end
        for (int cyc = 2; cyc <= 20 && !done_seen; cyc++) begin
            @(negedge i_clk);
            #1;
            if (o_done) done_seen = 1'b1;
        end
        n_vec++; if (!done_seen) begin n_err++; $display("FAIL ck_timeout got=no_done want=done"); end
        n_vec++; if (o_chksum !== W'(7)) begin n_err++; $display("FAIL ck_done got=%h want=7", o_chksum); end
        repeat (2) @(negedge i_clk);
        #1;
        n_vec++; if (o_chksum !== W'(7)) begin n_err++; $display("FAIL ck_hold got=%h want=7", o_chksum); end
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_full(11'd1024);
        test_full(11'd2047);
        test_restart();
        test_reset_mid();
`ifdef OBUF_RD_CHKSUM_EN
        test_chksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
